// File: rtl/ej32_pkg.sv
// eJ32 shared definitions: console buffer layout and host I/O bridge state.
// Buffer bases are shared between the load/store unit and the I/O bridge.
package ej32_pkg;

    localparam int ASZ_DEF   = 17;
    localparam int TIB_BASE  = 'h1000;
    localparam int OBUF_BASE = 'h1400;
    localparam int TSZ_DEF   = 1024;
    localparam int OSZ_DEF   = 1024;

    typedef enum logic {
        IO_IDLE,
        IO_RD
    } io_state_t;

endpackage

// File: rtl/ej32_io_bridge.sv
// Host-side console bridge: streams host bytes into TIB and drains OBUF to the host
// over a second byte-wide memory port with one cycle of read latency.
module ej32_io_bridge
    import ej32_pkg::*;
#(
    parameter int ASZ  = ASZ_DEF,
    parameter int TIB  = TIB_BASE,
    parameter int OBUF = OBUF_BASE,
    parameter int TSZ  = TSZ_DEF,
    parameter int OSZ  = OSZ_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           rx_valid,
    input  logic [7:0]     rx_data,
    output logic           rx_ready,
    output logic           tx_valid,
    output logic [7:0]     tx_data,
    input  logic           tx_ready,
    input  logic [ASZ-1:0] core_obuf,
    output logic [ASZ-1:0] tib_wp,
    output logic [ASZ-1:0] mem_a,
    output logic           mem_we,
    output logic [7:0]     mem_vi,
    input  logic [7:0]     mem_vo
);

    localparam logic [ASZ-1:0] TIB_A    = ASZ'(TIB);
    localparam logic [ASZ-1:0] TIB_END  = ASZ'(TIB + TSZ);
    localparam logic [ASZ-1:0] OBUF_A   = ASZ'(OBUF);
    localparam logic [ASZ-1:0] OBUF_END = ASZ'(OBUF + OSZ);
    localparam logic [ASZ-1:0] ONE      = ASZ'(1);

    io_state_t      state;
    io_state_t      state_nx;
    logic [ASZ-1:0] ob_rp;
    logic           prio;
    logic           clr;
    logic           rx_req;
    logic           tx_req;
    logic           grant_rx;
    logic           grant_tx;
    logic           contested;

    assign clr = rst || flush;

    always_comb begin
        state_nx  = state;
        rx_req    = 1'b0;
        tx_req    = 1'b0;
        mem_a     = ob_rp;
        mem_we    = 1'b0;
        mem_vi    = rx_data;
        rx_ready  = 1'b0;

        if (state == IO_IDLE) begin
            rx_req = rx_valid && (tib_wp < TIB_END);
            // a pending output byte may only be replaced when the host takes it now
            tx_req = (ob_rp != core_obuf) && (ob_rp < OBUF_END)
                     && (!tx_valid || tx_ready);
        end

        grant_rx  = rx_req && (!tx_req || !prio);
        grant_tx  = tx_req && (!rx_req || prio);
        contested = rx_req && tx_req;

        unique case (state)
            IO_IDLE: begin
                if (grant_rx) begin
                    rx_ready = 1'b1;
                    mem_we   = 1'b1;
                    mem_a    = tib_wp;
                end else if (grant_tx) begin
                    state_nx = IO_RD;
                end
            end
            IO_RD: begin
                state_nx = IO_IDLE;
            end
        endcase

        if (clr) begin
            mem_we   = 1'b0;
            rx_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IO_IDLE;
            tib_wp   <= TIB_A;
            ob_rp    <= OBUF_A;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            prio     <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant_rx) begin
                tib_wp <= tib_wp + ONE;
            end
            if (contested) begin
                prio <= !prio;
            end
            if (state == IO_RD) begin
                tx_data  <= mem_vo;
                tx_valid <= 1'b1;
                ob_rp    <= ob_rp + ONE;
            end else if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule
